// File: rtl/seq_bit_serializer_pkg.sv
// seq_pkg: shared FSM state encoding and idle-level default for the serial feeder
package seq_pkg;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam logic SER_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// seq_bit_serializer_if: valid/ready word handshake feeding the serializer
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/seq_bit_serializer_fifo.sv
// seq_word_fifo: small word buffer with occupancy count, head-of-queue read and synchronous flush
module seq_word_fifo
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // next-state: pointers wrap naturally, occupancy comes from the count so full/empty never alias
    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(do_push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(do_pop);
        count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
    end

    // storage and pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: buffers parallel words and shifts them out one bit per clock, gap-free
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   DEPTH     = 4,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
    input  logic                        clk,
    input  logic                        reset,
    seq_bit_serializer_if.slave         in_if,
    input  logic                        flush,
    output logic                        x_out,
    output logic                        x_valid,
    output logic                        busy,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count
);

    localparam int         BW       = $clog2(WIDTH);
    localparam logic [0:0] ST_IDLE  = SER_IDLE;
    localparam logic [0:0] ST_SHIFT = SER_SHIFT;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             x_out_q, x_out_d;
    logic             x_valid_q, x_valid_d;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_full, fifo_empty;
    logic             push, pop;

    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    seq_word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (in_if.in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_if.in_ready = !fifo_full && !flush;
    assign push           = in_if.in_valid && in_if.in_ready;
    assign pop            = !flush && !fifo_empty && (state_q == ST_IDLE || bit_cnt_q == '0);
    assign x_out          = x_out_q;
    assign x_valid        = x_valid_q;
    assign busy           = state_q == ST_SHIFT || fifo_count != '0;

    // FSM: load the head word while idle or on the last bit (no bubble), otherwise shift or go idle
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        x_out_d   = x_out_q;
        x_valid_d = x_valid_q;
        if (flush) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            x_out_d   = IDLE_BIT;
            x_valid_d = 1'b0;
        end else if (pop) begin
            state_d   = ST_SHIFT;
            shreg_d   = fifo_dout;
            bit_cnt_d = BW'(WIDTH - 1);
            x_out_d   = lead_bit(fifo_dout);
            x_valid_d = 1'b1;
        end else if (state_q == ST_SHIFT && bit_cnt_q != '0) begin
            shreg_d   = shift_word(shreg_q);
            bit_cnt_d = bit_cnt_q - BW'(1);
            x_out_d   = lead_bit(shift_word(shreg_q));
        end else begin
            state_d   = ST_IDLE;
            x_out_d   = IDLE_BIT;
            x_valid_d = 1'b0;
        end
    end

    // shifter and registered serial outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            x_out_q   <= IDLE_BIT;
            x_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: scoreboard bench for an MSB-first and an LSB-first serializer instance
module tb_seq_bit_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush0 = 1'b0, flush1 = 1'b0;
    logic       x_out0, x_valid0, busy0, x_out1, x_valid1, busy1;
    logic [2:0] fifo_count0, fifo_count1;
    logic       sb0 [$];
    logic       sb1 [$];
    int         n_chk = 0, n_fail = 0;
    int         run0 = 0, last0 = 0, run1 = 0, last1 = 0;

    seq_bit_serializer_if #(.WIDTH(8)) if0 ();
    seq_bit_serializer_if #(.WIDTH(8)) if1 ();

    seq_bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .in_if(if0), .flush(flush0),
        .x_out(x_out0), .x_valid(x_valid0), .busy(busy0), .fifo_count(fifo_count0)
    );

    seq_bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .in_if(if1), .flush(flush1),
        .x_out(x_out1), .x_valid(x_valid1), .busy(busy1), .fifo_count(fifo_count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // serial monitors: every payload bit is popped from the scoreboard, idle level checked otherwise
    always @(negedge clk) begin
        if (!reset) run0 = 0;
        else if (x_valid0) begin
            run0++;
            chk("dut0 bit expected", sb0.size() != 0, 1);
            if (sb0.size() != 0) chk("dut0 bit", x_out0, sb0.pop_front());
        end else begin
            if (run0 != 0) last0 = run0;
            run0 = 0;
            chk("dut0 idle level", x_out0, 0);
        end
    end

    always @(negedge clk) begin
        if (!reset) run1 = 0;
        else if (x_valid1) begin
            run1++;
            chk("dut1 bit expected", sb1.size() != 0, 1);
            if (sb1.size() != 0) chk("dut1 bit", x_out1, sb1.pop_front());
        end else begin
            if (run1 != 0) last1 = run1;
            run1 = 0;
            chk("dut1 idle level", x_out1, 0);
        end
    end

    task automatic push(input bit sel, input logic [7:0] w);
        int t = 0;
        @(negedge clk);
        if (sel) begin if1.in_valid = 1'b1; if1.in_data = w; end
        else begin if0.in_valid = 1'b1; if0.in_data = w; end
        while (!(sel ? if1.in_ready : if0.in_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("push accepted in time", t < 200, 1);
        for (int i = 0; i < 8; i++) begin
            if (sel) sb1.push_back(w[i]);
            else sb0.push_back(w[7-i]);
        end
        @(posedge clk);
        #1;
        if (sel) if1.in_valid = 1'b0;
        else if0.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((sel ? (busy1 || x_valid1) : (busy0 || x_valid0)) && t < 300);
        #1;
        chk("drained in time", t < 300, 1);
        chk("scoreboard drained", sel ? sb1.size() : sb0.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        if0.in_valid = 1'b0; if0.in_data = '0;
        if1.in_valid = 1'b0; if1.in_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset x_out", x_out0, 0);
        chk("reset x_valid", x_valid0, 0);
        chk("reset busy", busy0, 0);
        chk("reset in_ready", if0.in_ready, 1);
        chk("reset fifo_count", fifo_count0, 0);

        push(0, 8'b0101_1100);
        chk("no bit on push edge", x_valid0, 0);
        chk("count after push", fifo_count0, 1);
        chk("busy after push", busy0, 1);
        @(posedge clk);
        #1;
        chk("first bit valid one edge after push", x_valid0, 1);
        chk("first bit value", x_out0, 0);
        chk("count after pop", fifo_count0, 0);
        wait_idle(0);
        chk("single word run length", last0, 8);

        push(0, 8'hA5);
        push(0, 8'h3C);
        wait_idle(0);
        chk("back-to-back run length", last0, 16);

        for (int i = 0; i < 5; i++) push(0, 8'(8'h11 * (i + 1)));
        chk("count at full", fifo_count0, 4);
        chk("in_ready low when full", if0.in_ready, 0);
        push(0, 8'h66);
        wait_idle(0);
        chk("six-word run length", last0, 48);

        push(0, 8'hFF);
        push(0, 8'h12);
        push(0, 8'h34);
        repeat (3) @(negedge clk);
        chk("bit 3 of FF shifting", x_valid0, 1);
        chk("two words queued", fifo_count0, 2);
        flush0 = 1'b1;
        if0.in_valid = 1'b1;
        if0.in_data = 8'h55;
        #1;
        chk("in_ready low during flush", if0.in_ready, 0);
        @(posedge clk);
        #1;
        flush0 = 1'b0;
        if0.in_valid = 1'b0;
        sb0.delete();
        chk("flush x_valid", x_valid0, 0);
        chk("flush x_out", x_out0, 0);
        chk("flush fifo_count", fifo_count0, 0);
        chk("flush busy", busy0, 0);
        push(0, 8'h81);
        wait_idle(0);
        chk("post-flush run length", last0, 8);

        push(1, 8'hF0);
        repeat (3) @(negedge clk);
        chk("dut1 mid-word", x_valid1, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset x_valid", x_valid1, 0);
        chk("async reset x_out", x_out1, 0);
        chk("async reset busy", busy1, 0);
        chk("async reset fifo_count", fifo_count1, 0);
        sb0.delete();
        sb1.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("in_ready after release", if1.in_ready, 1);
        repeat (3) @(negedge clk);
        chk("no resume x_valid", x_valid1, 0);
        chk("no resume busy", busy1, 0);
        push(1, 8'h01);
        wait_idle(1);
        chk("lsb-first run length", last1, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
